// File: rtl/uart_mem_pkg.sv
// uart_mem_pkg: shared types and constants for the UART accumulator/responder.
//   state_t          top-level sequencing states
//   BYTES_PER_REC    bytes per received record (two big-endian 32-bit operands)
//   BYTES_PER_RES    bytes per transmitted result word
//   FRAME_*          8N1 framing constants used by both UART cores
package uart_mem_pkg;

    typedef enum logic [2:0] {
        ST_RECV,
        ST_RDONE,
        ST_LOAD,
        ST_SENDW,
        ST_SDONE
    } state_t;

    localparam int BYTES_PER_REC = 8;
    localparam int BYTES_PER_RES = 4;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic FRAME_START_BIT = 1'b0;
    localparam logic FRAME_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_mem_uart.sv
// uart_rx / uart_tx: 8N1 UART cores, one bit per CLKS_PER_BIT clocks.
// uart_rx ports:
//   i_Clock, rst (async active-high), i_Rx_Serial (idle high)
//   o_Rx_DV (1-clock strobe), o_Rx_Byte (received byte, LSB first on the wire)
// uart_tx ports:
//   i_Clock, rst (async active-high), i_Tx_DV (1-clock load strobe), i_Tx_Byte
//   o_Tx_Active (frame in progress), o_Tx_Serial (idle high), o_Tx_Done (1-clock strobe
//   after the stop bit has been held for its full duration)
module uart_rx
    import uart_mem_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = 16'd100
) (
    input  logic       i_Clock,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   st;
    logic [1:0]  sync;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic        rx_s;

    assign rx_s = sync[1];

    // Return to idle at mid-stop so a start bit immediately following the
    // stop bit is still caught on its falling edge.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            sync      <= 2'b11;
            st        <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            o_Rx_DV   <= 1'b0;
            o_Rx_Byte <= '0;
        end else begin
            sync    <= {sync[0], i_Rx_Serial};
            o_Rx_DV <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_s == FRAME_START_BIT) begin
                        st  <= RX_START;
                        cnt <= (CLKS_PER_BIT >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        if (rx_s == FRAME_START_BIT) begin
                            st      <= RX_DATA;
                            cnt     <= CLKS_PER_BIT - 16'd1;
                            bit_idx <= '0;
                        end else begin
                            st <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        o_Rx_Byte[bit_idx] <= rx_s;
                        cnt                <= CLKS_PER_BIT - 16'd1;
                        if (bit_idx == 3'(FRAME_DATA_BITS - 1)) st <= RX_STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        o_Rx_DV <= (rx_s == FRAME_STOP_BIT);
                        st      <= RX_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

module uart_tx
    import uart_mem_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = 16'd100
) (
    input  logic       i_Clock,
    input  logic       rst,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t   st;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  data;

    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            st          <= TX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            data        <= '0;
            o_Tx_Serial <= FRAME_STOP_BIT;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (st)
                TX_IDLE: begin
                    o_Tx_Serial <= FRAME_STOP_BIT;
                    if (i_Tx_DV) begin
                        data        <= i_Tx_Byte;
                        st          <= TX_START;
                        cnt         <= CLKS_PER_BIT - 16'd1;
                        o_Tx_Serial <= FRAME_START_BIT;
                        o_Tx_Active <= 1'b1;
                    end
                end
                TX_START: begin
                    if (cnt == '0) begin
                        st          <= TX_DATA;
                        cnt         <= CLKS_PER_BIT - 16'd1;
                        bit_idx     <= '0;
                        o_Tx_Serial <= data[0];
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (cnt == '0) begin
                        cnt <= CLKS_PER_BIT - 16'd1;
                        if (bit_idx == 3'(FRAME_DATA_BITS - 1)) begin
                            st          <= TX_STOP;
                            o_Tx_Serial <= FRAME_STOP_BIT;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            o_Tx_Serial <= data[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (cnt == '0) begin
                        st          <= TX_IDLE;
                        o_Tx_Done   <= 1'b1;
                        o_Tx_Active <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: st <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mem.sv
// uart_mem: receives MEM_SIZE eight-byte records (A then B, each big-endian),
// stores A+B mod 2^32 per record, and on mem2uart returns the sums MSB-first.
// Ports:
//   clk, rst (async active-high)
//   mem2uart   level request to send results, honoured once reception is done
//   Rx_Serial  UART receive line (idle high)
//   recv_done  sticky: all records received and stored
//   send_done  sticky: all result bytes transmitted
//   Tx_Serial  UART transmit line (idle high)
//
// state    | meaning
// ST_RECV  | counting bytes, assembling operands, writing sums
// ST_RDONE | reception complete, waiting for mem2uart
// ST_LOAD  | hand the current result byte to the transmitter (1 clock)
// ST_SENDW | waiting for the transmitter to finish the byte
// ST_SDONE | everything sent; idle until reset
module uart_mem
    import uart_mem_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = 16'd100,
    parameter int          MEM_SIZE     = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic mem2uart,
    input  logic Rx_Serial,
    output logic recv_done,
    output logic send_done,
    output logic Tx_Serial
);

    localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    state_t          state, state_nx;
    logic            rx_dv, tx_dv, tx_active, tx_done;
    logic [7:0]      rx_byte, tx_byte;
    logic [2:0]      rx_cnt;
    logic [AW-1:0]   rec_idx, tx_idx;
    logic [55:0]     rec_sr;
    logic [1:0]      tx_bsel;
    logic            tx_last;
    logic            rec_end, stream_end;
    logic [31:0]     mem [MEM_SIZE];
    logic [31:0]     rd_word;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_Clock     (clk),
        .rst         (rst),
        .i_Rx_Serial (Rx_Serial),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Byte   (rx_byte)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_Clock     (clk),
        .rst         (rst),
        .i_Tx_DV     (tx_dv),
        .i_Tx_Byte   (tx_byte),
        .o_Tx_Active (tx_active),
        .o_Tx_Serial (Tx_Serial),
        .o_Tx_Done   (tx_done)
    );

    assign rec_end    = rx_dv && (rx_cnt == 3'(BYTES_PER_REC - 1));
    assign stream_end = rec_end && (rec_idx == AW'(MEM_SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_RECV;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RECV:  if (stream_end) state_nx = ST_RDONE;
            ST_RDONE: if (mem2uart && !tx_active) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ST_SENDW;
            ST_SENDW: if (tx_done) state_nx = tx_last ? ST_SDONE : ST_LOAD;
            ST_SDONE: state_nx = ST_SDONE;
            default:  state_nx = ST_RECV;
        endcase
    end

    always_comb begin
        recv_done = (state != ST_RECV);
        send_done = (state == ST_SDONE);
        tx_dv     = (state == ST_LOAD);
        case (tx_bsel)
            2'd0:    tx_byte = rd_word[31:24];
            2'd1:    tx_byte = rd_word[23:16];
            2'd2:    tx_byte = rd_word[15:8];
            default: tx_byte = rd_word[7:0];
        endcase
    end

    // Counters point at the byte being handed over in ST_LOAD and advance
    // right after, so the registered read has the whole of ST_SENDW to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt  <= '0;
            rec_idx <= '0;
            rec_sr  <= '0;
            tx_idx  <= '0;
            tx_bsel <= '0;
            tx_last <= 1'b0;
        end else begin
            if (state == ST_RECV && rx_dv) begin
                rec_sr <= {rec_sr[47:0], rx_byte};
                if (rec_end) begin
                    rx_cnt  <= '0;
                    rec_idx <= rec_idx + 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + 3'd1;
                end
            end
            if (state == ST_LOAD) begin
                tx_bsel <= tx_bsel + 2'd1;
                if (tx_bsel == 2'(BYTES_PER_RES - 1)) begin
                    tx_idx  <= tx_idx + 1'b1;
                    tx_last <= (tx_idx == AW'(MEM_SIZE - 1));
                end
            end
        end
    end

    // rec_sr holds bytes 0..6 when byte 7 arrives: A = [55:24], B = [23:0] & new byte.
    always_ff @(posedge clk) begin
        if (state == ST_RECV && rec_end)
            mem[rec_idx] <= rec_sr[55:24] + {rec_sr[23:0], rx_byte};
        rd_word <= mem[tx_idx];
    end

endmodule

// File: tb/tb_uart_mem.sv
module tb_uart_mem;

    localparam int CPB  = 10;
    localparam int MEMN = 4;
    localparam int NB_RX = 8 * MEMN;
    localparam int NB_TX = 4 * MEMN;

    logic clk, rst, mem2uart, Rx_Serial;
    logic recv_done, send_done, Tx_Serial;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] stim[$];
    logic [7:0] expq[$];

    uart_mem #(.CLKS_PER_BIT(16'(CPB)), .MEM_SIZE(MEMN)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem2uart  (mem2uart),
        .Rx_Serial (Rx_Serial),
        .recv_done (recv_done),
        .send_done (send_done),
        .Tx_Serial (Tx_Serial)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Reference model: each record's sum sent back most significant byte first.
    task automatic build(input bit directed);
        logic [31:0] a, b, s;
        stim.delete();
        expq.delete();
        for (int r = 0; r < MEMN; r++) begin
            a = $urandom; b = $urandom;
            if (directed && r == 0) begin a = 32'h0000_0001; b = 32'h0000_0002; end
            if (directed && r == 1) begin a = 32'hFFFF_FFFF; b = 32'h0000_0003; end
            for (int k = 3; k >= 0; k--) stim.push_back(8'((a >> (8 * k)) & 32'hFF));
            for (int k = 3; k >= 0; k--) stim.push_back(8'((b >> (8 * k)) & 32'hFF));
            s = a + b;
            for (int k = 3; k >= 0; k--) expq.push_back(8'((s >> (8 * k)) & 32'hFF));
        end
    endtask

    // Drives one frame starting at the current negedge; reports how many clocks
    // into the frame recv_done was first seen high (-1 if never).
    task automatic send_byte(input logic [7:0] b, output int rd_off);
        logic v;
        int t;
        rd_off = -1;
        t = 0;
        for (int k = 0; k < 10; k++) begin
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            Rx_Serial = v;
            repeat (CPB) begin
                @(negedge clk);
                t++;
                if (recv_done === 1'b1 && rd_off < 0) rd_off = t;
            end
        end
    endtask

    task automatic send_stream(output int last_off);
        int off;
        last_off = -1;
        for (int i = 0; i < NB_RX; i++) begin
            send_byte(stim[i], off);
            if (i == NB_RX - 2) chk("recv_done_early", (off < 0), 1);
            if (i == NB_RX - 1) last_off = off;
        end
    endtask

    task automatic rx_tx_byte(output logic [7:0] b, output int s, output bit ok);
        ok = 1'b0;
        s = -1;
        b = '0;
        for (int t = 0; t < 40 * CPB; t++) begin
            @(posedge clk); #1;
            if (Tx_Serial === 1'b0) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) return;
        wait_until(s + CPB / 2);
        if (Tx_Serial !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            wait_until(s + CPB / 2 + CPB * (i + 1));
            b[i] = Tx_Serial;
        end
        wait_until(s + CPB / 2 + 9 * CPB);
        ok = (Tx_Serial === 1'b1);
    endtask

    task automatic recv_all(input int ref_cyc);
        logic [7:0] b;
        int s, prev_s;
        bit ok;
        prev_s = 0;
        for (int n = 0; n < NB_TX; n++) begin
            rx_tx_byte(b, s, ok);
            chk($sformatf("frame_ok[%0d]", n), ok, 1);
            chk($sformatf("tx_byte[%0d]", n), b, expq[n]);
            if (n == 0) chk("first_start_latency", (s > ref_cyc && s <= ref_cyc + 3), 1);
            else        chk($sformatf("gap[%0d]", n), (s - prev_s >= 10 * CPB && s - prev_s <= 10 * CPB + 3), 1);
            prev_s = s;
        end
        wait_until(prev_s + 10 * CPB - 1);
        chk("last_stop_full", {Tx_Serial, send_done}, 2'b10);
        wait_until(prev_s + 10 * CPB + 2);
        chk("send_done_rise", send_done, 1);
    endtask

    task automatic quiet_after_send();
        bit bad;
        bad = 1'b0;
        mem2uart = 1'b0;
        repeat (5) @(posedge clk);
        mem2uart = 1'b1;
        for (int t = 0; t < 30 * CPB; t++) begin
            @(posedge clk); #1;
            if (Tx_Serial !== 1'b1 || send_done !== 1'b1 || recv_done !== 1'b1) bad = 1'b1;
        end
        chk("no_extra_tx", bad, 0);
    endtask

    initial begin
        int off_a, off_b, rd_cyc, dummy;
        bit early_tx, seen;

        rst = 1'b1; mem2uart = 1'b0; Rx_Serial = 1'b1;
        #200;
        @(posedge clk); #1;
        chk("reset_outputs", {Tx_Serial, recv_done, send_done}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 5 * CPB; t++) begin
            @(posedge clk); #1;
            if (t % 10 == 0) chk("idle_outputs", {Tx_Serial, recv_done, send_done}, 3'b100);
        end

        // Short low glitch during idle must not be counted as a byte.
        @(negedge clk);
        Rx_Serial = 1'b0;
        repeat (CPB * 3 / 10) @(negedge clk);
        Rx_Serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Run A: directed wrap records plus random ones, back-to-back frames.
        build(1'b1);
        send_stream(off_a);
        chk("recv_done_off_range", (off_a >= 9 * CPB && off_a <= 10 * CPB), 1);
        early_tx = 1'b0;
        for (int t = 0; t < 5 * CPB; t++) begin
            @(posedge clk); #1;
            if (Tx_Serial !== 1'b1 || send_done !== 1'b0) early_tx = 1'b1;
        end
        chk("idle_until_mem2uart", early_tx, 0);
        @(negedge clk);
        mem2uart = 1'b1;
        recv_all(cyc);
        quiet_after_send();

        // Reset in the middle of byte 5 of a new stream.
        mem2uart = 1'b0;
        build(1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_byte(stim[i], dummy);
        Rx_Serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            Rx_Serial = stim[4][k];
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b1;
        Rx_Serial = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_reset_outputs", {Tx_Serial, recv_done, send_done}, 3'b100);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        chk("post_reset_idle", {Tx_Serial, recv_done, send_done}, 3'b100);

        // Run B: full resend with mem2uart already high.
        mem2uart = 1'b1;
        fork
            begin
                send_stream(off_b);
            end
            begin
                early_tx = 1'b0;
                seen = 1'b0;
                rd_cyc = 0;
                for (int t = 0; t < 20000; t++) begin
                    @(posedge clk); #1;
                    if (recv_done === 1'b1) begin
                        seen = 1'b1;
                        rd_cyc = cyc;
                        break;
                    end
                    if (Tx_Serial !== 1'b1) early_tx = 1'b1;
                end
                chk("recv_done_seen", seen, 1);
                chk("no_tx_before_recv_done", early_tx, 0);
                recv_all(rd_cyc);
            end
        join
        chk("recv_done_timing_same", off_b, off_a);
        quiet_after_send();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
